// File: rtl/fir_frame_controller.sv
// Address/flag sequencer for the two-pass separable FIR denoiser (raster H pass, column-major V pass).
// Optional stall counter port stall_cnt is enabled by defining FIR_CTRL_PERF_CNT_EN.
module fir_frame_controller #(
    parameter int IMAGE_WIDTH  = 110,
    parameter int IMAGE_HEIGHT = 103,
    parameter int ADDR_WIDTH   = 14,
    parameter int FILTER_LAT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  ready_in,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    output logic                  line_start,
    output logic                  line_end,
    output logic                  pass_sel,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_en,
    output logic                  busy,
    output logic                  done
`ifdef FIR_CTRL_PERF_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [3:0]       DRAIN_LAST = 4'(FILTER_LAT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_H_PASS  = 3'd1;
    localparam logic [2:0] S_H_DRAIN = 3'd2;
    localparam logic [2:0] S_V_PASS  = 3'd3;
    localparam logic [2:0] S_V_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            drain_q, drain_d;

    logic [FILTER_LAT-1:0] wr_en_pipe_q;
    logic [ADDR_WIDTH-1:0] wr_addr_pipe_q [FILTER_LAT];

    logic in_h, in_v, reading, abort_hit;

    assign in_h      = (state_q == S_H_PASS);
    assign in_v      = (state_q == S_V_PASS);
    assign reading   = (in_h || in_v) && ready_in;
    assign abort_hit = abort && (state_q != S_IDLE);

    assign rd_en      = reading;
    assign rd_addr    = addr_q;
    assign line_start = reading && (in_h ? (col_q == '0) : (row_q == '0));
    assign line_end   = reading && (in_h ? (col_q == COL_LAST) : (row_q == ROW_LAST));
    assign pass_sel   = (state_q == S_V_PASS) || (state_q == S_V_DRAIN) || (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign wr_en      = wr_en_pipe_q[FILTER_LAT-1];
    assign wr_addr    = wr_addr_pipe_q[FILTER_LAT-1];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        drain_d = drain_q;

        if (abort_hit) begin
            state_d = S_IDLE;
            col_d   = '0;
            row_d   = '0;
            addr_d  = '0;
            drain_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_H_PASS;
                        col_d   = '0;
                        row_d   = '0;
                        addr_d  = '0;
                    end
                end
                S_H_PASS: begin
                    if (ready_in) begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                row_d   = '0;
                                addr_d  = '0;
                                drain_d = '0;
                                state_d = S_H_DRAIN;
                            end else begin
                                row_d = row_q + ROW_W'(1);
                            end
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
                S_H_DRAIN: begin
                    drain_d = drain_q + 4'd1;
                    if (drain_q == DRAIN_LAST) begin
                        drain_d = '0;
                        state_d = S_V_PASS;
                    end
                end
                S_V_PASS: begin
                    if (ready_in) begin
                        if (row_q == ROW_LAST) begin
                            row_d = '0;
                            if (col_q == COL_LAST) begin
                                col_d   = '0;
                                addr_d  = '0;
                                drain_d = '0;
                                state_d = S_V_DRAIN;
                            end else begin
                                // Column wrap: the next column's top pixel address equals its index.
                                col_d  = col_q + COL_W'(1);
                                addr_d = ADDR_WIDTH'(col_q) + ADDR_WIDTH'(1);
                            end
                        end else begin
                            row_d  = row_q + ROW_W'(1);
                            addr_d = addr_q + ADDR_WIDTH'(IMAGE_WIDTH);
                        end
                    end
                end
                S_V_DRAIN: begin
                    drain_d = drain_q + 4'd1;
                    if (drain_q == DRAIN_LAST) begin
                        drain_d = '0;
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the delay line is reset explicitly; stale entries would otherwise emit spurious writes.
        if (!reset) begin
            for (int i = 0; i < FILTER_LAT; i++) begin
                wr_en_pipe_q[i]   <= 1'b0;
                wr_addr_pipe_q[i] <= '0;
            end
        end else if (abort_hit) begin
            for (int i = 0; i < FILTER_LAT; i++) begin
                wr_en_pipe_q[i]   <= 1'b0;
                wr_addr_pipe_q[i] <= '0;
            end
        end else begin
            wr_en_pipe_q[0]   <= rd_en;
            wr_addr_pipe_q[0] <= addr_q;
            for (int i = 1; i < FILTER_LAT; i++) begin
                wr_en_pipe_q[i]   <= wr_en_pipe_q[i-1];
                wr_addr_pipe_q[i] <= wr_addr_pipe_q[i-1];
            end
        end
    end

`ifdef FIR_CTRL_PERF_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if ((state_q == S_IDLE) && start && !abort) begin
            stall_q <= '0;
        end else if ((in_h || in_v) && !ready_in && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fir_frame_controller.sv
// Scoreboard bench for fir_frame_controller at W=4, H=3, FILTER_LAT=2.
// Stimulus pushes expected reads/writes/done; a negedge monitor pops and compares.
module tb_fir_frame_controller;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int LAT = 2;
    localparam int AW  = 14;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic          ready_in;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic          line_start;
    logic          line_end;
    logic          pass_sel;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          busy;
    logic          done;
`ifdef FIR_CTRL_PERF_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    fir_frame_controller #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .ADDR_WIDTH  (AW),
        .FILTER_LAT  (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .ready_in  (ready_in),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .line_start(line_start),
        .line_end  (line_end),
        .pass_sel  (pass_sel),
        .wr_addr   (wr_addr),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done)
`ifdef FIR_CTRL_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct {
        int a;
        int ls;
        int le;
        int ps;
        int c;
    } rd_t;

    typedef struct {
        int a;
        int c;
    } wr_t;

    rd_t rd_q[$];
    wr_t wr_q[$];
    int  done_q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int done_cnt = 0;
    int last_done_cyc = -1;

    // Column-major read order of a 4x3 image, worked out by hand.
    int v_tab [12] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push expected traffic for one frame started at cycle t0.
    task automatic push_frame(input int t0, input int stall_idx, input int stall_len, input int v_reads);
        int  c;
        rd_t r;
        wr_t w;
        bit  full;
        full = (v_reads == W * H);
        c = t0 + 1;
        for (int i = 0; i < W * H; i++) begin
            if (i == stall_idx) c += stall_len;
            r = '{a: i, ls: int'(i % W == 0), le: int'(i % W == W - 1), ps: 0, c: c};
            w = '{a: i, c: c + LAT};
            rd_q.push_back(r);
            wr_q.push_back(w);
            c++;
        end
        c += LAT;
        for (int k = 0; k < v_reads; k++) begin
            r = '{a: v_tab[k], ls: int'(v_tab[k] < W), le: int'(v_tab[k] >= W * (H - 1)), ps: 1, c: c};
            rd_q.push_back(r);
            if (full) begin
                w = '{a: v_tab[k], c: c + LAT};
                wr_q.push_back(w);
            end
            c++;
        end
        if (full) done_q.push_back(c + LAT);
    endtask

    // Monitor: compares every presented read, write and done against the scoreboard.
    initial begin
        rd_t r;
        wr_t w;
        int  d;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (rd_en) begin
                    if (rd_q.size() == 0) begin
                        check("rd_unexpected", 1, 0);
                    end else begin
                        r = rd_q.pop_front();
                        check("rd_addr", rd_addr, r.a);
                        check("rd_line_start", line_start, r.ls);
                        check("rd_line_end", line_end, r.le);
                        check("rd_pass_sel", pass_sel, r.ps);
                        check("rd_cycle", cyc, r.c);
                    end
                end
                if (wr_en) begin
                    if (wr_q.size() == 0) begin
                        check("wr_unexpected", 1, 0);
                    end else begin
                        w = wr_q.pop_front();
                        check("wr_addr", wr_addr, w.a);
                        check("wr_cycle", cyc, w.c);
                    end
                end
                if (done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                    if (done_q.size() == 0) begin
                        check("done_unexpected", 1, 0);
                    end else begin
                        d = done_q.pop_front();
                        check("done_cycle", cyc, d);
                        check("done_busy_low", busy, 0);
                    end
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_line_start"}, line_start, 0);
        check({tag, "_line_end"}, line_end, 0);
        check({tag, "_pass_sel"}, pass_sel, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic start_frame(output int t0);
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int t0, input int rel);
        int n0;
        bit seen;
        n0 = done_cnt;
        seen = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            tick();
            if (done_cnt != n0) seen = 1;
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_done_at"}, last_done_cyc - t0, rel);
        repeat (6) tick();
        check({tag, "_one_done"}, done_cnt - n0, 1);
        check({tag, "_rd_drained"}, rd_q.size(), 0);
        check({tag, "_wr_drained"}, wr_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n0;
        reset    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        ready_in = 1'b1;
        #3;
        check_outputs_zero("por");
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // Nominal frame: done at cycle 29.
        push_frame(cyc, -1, 0, W * H);
        start_frame(t0);
        wait_done("nominal", t0, 29);

        // Backpressure for 3 cycles at rd_addr=5: done at cycle 32.
        push_frame(cyc, 5, 3, W * H);
        start_frame(t0);
        while (cyc < t0 + 6) tick();
        ready_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_rd_en", rd_en, 0);
            check("stall_rd_addr", rd_addr, 5);
            check("stall_busy", busy, 1);
            tick();
        end
        ready_in = 1'b1;
        wait_done("stall", t0, 32);
`ifdef FIR_CTRL_PERF_CNT_EN
        check("stall_cnt", stall_cnt, 3);
`endif

        // Abort on the first V_PASS read.
        n0 = done_cnt;
        push_frame(cyc, -1, 0, 1);
        start_frame(t0);
        while (cyc < t0 + 15) tick();
        abort = 1'b1;
        @(negedge clk);
        check("abort_pass_sel", pass_sel, 1);
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_rd_en", rd_en, 0);
        check("abort_wr_en", wr_en, 0);
        repeat (40) tick();
        check("abort_no_done", done_cnt - n0, 0);
        check("abort_rd_drained", rd_q.size(), 0);

        // A following frame must run normally.
        push_frame(cyc, -1, 0, W * H);
        start_frame(t0);
        wait_done("post_abort", t0, 29);

        // start pulsed mid H_PASS is ignored.
        push_frame(cyc, -1, 0, W * H);
        start_frame(t0);
        while (cyc < t0 + 5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("restart_ignored", t0, 29);

        // Async reset in the V pass.
        n0 = done_cnt;
        push_frame(cyc, -1, 0, W * H);
        start_frame(t0);
        while (cyc < t0 + 17) tick();
        check("pre_reset_pass_sel", pass_sel, 1);
        reset = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        tick();
        tick();
        reset = 1'b1;
        repeat (4) begin
            tick();
            check("post_reset_busy", busy, 0);
            check("post_reset_rd_en", rd_en, 0);
            check("post_reset_wr_en", wr_en, 0);
        end
        repeat (30) tick();
        check("post_reset_no_done", done_cnt - n0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_frame_controller.md
Name: fir_frame_controller

Overview:
Sequencer for the two-pass separable FIR denoiser.
- Horizontal pass: reads the source image in raster order and writes the row-filtered result to the intermediate buffer.
- Vertical pass: reads the intermediate buffer column-major and writes the column-filtered result to the output buffer.
- Generates read/write addresses, line-boundary flags for filter edge handling, and start/done handshaking.
- Sits between the image ROM/intermediate RAM and the FIR datapath.

Parameters:
IMAGE_WIDTH, 110, pixels per row
IMAGE_HEIGHT, 103, rows per frame
ADDR_WIDTH, 14, address width; must satisfy 2^ADDR_WIDTH >= IMAGE_WIDTH*IMAGE_HEIGHT
FILTER_LAT, 4, cycles from rd_en to filter output valid (includes 1-cycle memory read latency); range 1..15

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  frame start request; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE
ready_in  in  1  datapath can accept a new sample this cycle
rd_addr  out  ADDR_WIDTH  read address (ROM in H pass, intermediate RAM in V pass)
rd_en  out  1  read issued this cycle
line_start  out  1  qualified by rd_en; first pixel of current line
line_end  out  1  qualified by rd_en; last pixel of current line
pass_sel  out  1  0 = horizontal pass, 1 = vertical pass
wr_addr  out  ADDR_WIDTH  write address for filtered sample
wr_en  out  1  filtered sample valid; write this cycle
busy  out  1  frame in progress
done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (reset=0, async): FSM=IDLE; counters, address registers and write delay line cleared; every output 0.
- FSM states: IDLE, H_PASS, H_DRAIN, V_PASS, V_DRAIN, DONE.
- IDLE: start=1 -> H_PASS next cycle; busy=1 from that cycle.
- H_PASS: each cycle with ready_in=1 → rd_en=1, rd_addr=row*W+col, col is the inner counter. Address generated incrementally (+1), no multiplier.
- H_PASS line flags: line_start=(col==0), line_end=(col==W-1).
- ready_in=0 → rd_en=0; counters/addr hold; no read is issued.
- After the read at (H-1,W-1) -> H_DRAIN.
- H_DRAIN: no reads; hold exactly FILTER_LAT cycles -> V_PASS; pass_sel=1 from V_PASS entry.
- V_PASS: column-major order; row is the inner counter.
  - Address steps +W; at row==H-1 it restarts at col+1.
  - line_start=(row==0), line_end=(row==H-1).
  - Same ready_in gating as H_PASS.
  - After the read at (H-1,W-1) -> V_DRAIN.
- V_DRAIN: FILTER_LAT cycles -> DONE.
- DONE: done=1 and busy=0 for one cycle -> IDLE.
- Write side:
  - wr_en and wr_addr are rd_en and rd_addr delayed exactly FILTER_LAT cycles through a shift register, regardless of ready_in.
  - In-flight samples always complete.
- pass_sel changes only at state entry. The drain guarantees no write of one pass overlaps reads of the next.
- start while busy: ignored.
- abort=1 in any non-IDLE state: next cycle FSM=IDLE, busy=0, rd_en=0; delay line flushed so wr_en=0; no done pulse.
- abort has priority over start on the same cycle.
- Async reset mid-frame: immediate return to reset state; frame discarded.

Optional Feature:
FIR_CTRL_PERF_CNT_EN
- Defined: adds output port stall_cnt (16-bit).
  - Counts cycles in H_PASS/V_PASS with ready_in=0.
  - Saturates at 16'hFFFF.
  - Cleared when start is accepted; holds after DONE.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset: hold reset=0 mid-frame -> all outputs 0 immediately; after release, FSM idle, busy=0.
- Full frame, W=4, H=3, LAT=2, ready_in=1, start at cycle 0:
  - H reads: addr 0..11 at cycles 1..12; writes: addr 0..11 at cycles 3..14.
  - V reads: 0,4,8,1,5,9,2,6,10,3,7,11 at cycles 15..26; last write at cycle 28.
  - done=1 at cycle 29 only.
- Line flags, same setup:
  - H pass: line_start at addr 0,4,8; line_end at addr 3,7,11.
  - V pass: line_start at addr 0,1,2,3; line_end at addr 8,9,10,11.
- Backpressure: ready_in=0 for 3 cycles when rd_addr=5 in H pass -> rd_en=0 and addr holds 5; pending writes still complete; done moves to cycle 32; stall_cnt=3 with FIR_CTRL_PERF_CNT_EN.
- Abort at first V_PASS read -> next cycle busy=0, rd_en=0, wr_en=0; no done pulse; a following start runs a full frame correctly.
- start pulsed during H_PASS -> no effect on addresses; exactly one done pulse for the frame.
